rom_digit_serial_mult: RTL and testbench

//  Sequential WIDTH x WIDTH unsigned multiplier built on a 2x2 lookup-table digit multiplier.
//  - Splits each operand into 2-bit digits.
//  - Feeds one digit pair per cycle to the lookup and shift-accumulates the 4-bit partial products.
//  - Sits directly downstream of the operand source and wraps the 2x2 lookup stage.
//  - Gives the datapath a valid/ready multiply unit wider than 2 bits without a full array multiplier.

---
 rtl/rom_mult_pkg.sv | 26 ++
 rtl/digit_rom_2x2.sv | 34 +++
 rtl/rom_digit_serial_mult.sv | 133 +++++++++++++
 tb/tb_rom_digit_serial_mult.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/rom_mult_pkg.sv
// Shared types and elaboration helpers for the digit-serial lookup multiplier.
// Latency: none (package only).
// Backpressure: n/a.
package rom_mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of 2-bit digits in an operand of the given width.
  function automatic int digits(input int width);
    return width / 2;
  endfunction

  // Digit counter width; a one-digit operand still needs a 1-bit counter.
  function automatic int cnt_w(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  function automatic bit width_ok(input int width);
    return (width >= 2) && ((width % 2) == 0);
  endfunction

endpackage

// File: rtl/digit_rom_2x2.sv
// 2-bit x 2-bit unsigned multiply as a 16-entry lookup table.
// Latency: combinational.
// Backpressure: none.
// Ports: da, db - 2-bit digits; dp - 4-bit product da*db.
module digit_rom_2x2 (
  input  logic [1:0] da,
  input  logic [1:0] db,
  output logic [3:0] dp
);

  always_comb begin
    dp = 4'd0;
    case ({da, db})
      4'b00_00: dp = 4'd0;
      4'b00_01: dp = 4'd0;
      4'b00_10: dp = 4'd0;
      4'b00_11: dp = 4'd0;
      4'b01_00: dp = 4'd0;
      4'b01_01: dp = 4'd1;
      4'b01_10: dp = 4'd2;
      4'b01_11: dp = 4'd3;
      4'b10_00: dp = 4'd0;
      4'b10_01: dp = 4'd2;
      4'b10_10: dp = 4'd4;
      4'b10_11: dp = 4'd6;
      4'b11_00: dp = 4'd0;
      4'b11_01: dp = 4'd3;
      4'b11_10: dp = 4'd6;
      4'b11_11: dp = 4'b1001;
      default:  dp = 4'd0;
    endcase
  end

endmodule

// File: rtl/rom_digit_serial_mult.sv
// Sequential WIDTH x WIDTH unsigned multiplier, one 2x2 lookup digit product per cycle.
// Latency: out_valid rises N*N cycles after the accepting edge (N = WIDTH/2).
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
// Ports: clk, rst (async, active-high); in_valid/in_ready/a/b operand handshake;
//        out_valid/out_ready/prod result handshake; busy high in RUN or DONE.
module rom_digit_serial_mult
  import rom_mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy
);

  localparam int N  = digits(WIDTH);
  localparam int CW = cnt_w(N);
  localparam int PW = 2 * WIDTH;

  generate
    if (!width_ok(WIDTH)) begin : g_bad_width
      $error("rom_digit_serial_mult: WIDTH must be even and >= 2");
    end
  endgenerate

  state_t          state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic [CW-1:0]    i, j;
  logic [PW-1:0]    acc;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [1:0]       da, db;
  logic [3:0]       dp;
  logic [CW:0]      ij_sum;
  logic [PW-1:0]    term;
  logic             last_i, last_j;

  // Digit select: shift the held operand right by 2*index, keep the low digit.
  assign a_sh = a_r >> {i, 1'b0};
  assign b_sh = b_r >> {j, 1'b0};
  assign da   = a_sh[1:0];
  assign db   = b_sh[1:0];

  digit_rom_2x2 u_rom (
    .da (da),
    .db (db),
    .dp (dp)
  );

  // Partial product weight is 4^(i+j); max shift 2*WIDTH-4 keeps it inside acc.
  assign ij_sum = {1'b0, i} + {1'b0, j};
  assign term   = PW'(dp) << {ij_sum, 1'b0};

  assign last_i = (i == CW'(N - 1));
  assign last_j = (j == CW'(N - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last_i && last_j) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
        busy      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r <= '0;
      b_r <= '0;
      i   <= '0;
      j   <= '0;
      acc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_r <= a;
            b_r <= b;
            i   <= '0;
            j   <= '0;
            acc <= '0;
          end
        end
        RUN: begin
          acc <= acc + term;
          if (last_j) begin
            j <= '0;
            // Wrap i on the final term so a non-power-of-two N never overflows it.
            i <= last_i ? '0 : i + 1'b1;
          end else begin
            j <= j + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign prod = acc;

endmodule

// File: tb/tb_rom_digit_serial_mult.sv
module tb_rom_digit_serial_mult;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // WIDTH=8 instance
  logic        iv8 = 0, or8 = 0, ir8, ov8, bz8;
  logic [7:0]  a8 = 0, b8 = 0;
  logic [15:0] p8;
  // WIDTH=4 instance
  logic        iv4 = 0, or4 = 0, ir4, ov4, bz4;
  logic [3:0]  a4 = 0, b4 = 0;
  logic [7:0]  p4;
  // WIDTH=2 instance
  logic        iv2 = 0, or2 = 0, ir2, ov2, bz2;
  logic [1:0]  a2 = 0, b2 = 0;
  logic [3:0]  p2;

  rom_digit_serial_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .out_valid(ov8), .out_ready(or8), .prod(p8), .busy(bz8));
  rom_digit_serial_mult #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .out_valid(ov4), .out_ready(or4), .prod(p4), .busy(bz4));
  rom_digit_serial_mult #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(iv2), .in_ready(ir2), .a(a2), .b(b2),
    .out_valid(ov2), .out_ready(or2), .prod(p2), .busy(bz2));

  int checks = 0;
  int failures = 0;
  logic [15:0] q8[$];
  logic [7:0]  q4[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept8(input logic [7:0] av, input logic [7:0] bv);
    int n;
    n = 0;
    while (!ir8 && n < 50) begin tick(); n++; end
    check("in_ready8_wait", 32'(ir8), 32'd1);
    a8 = av; b8 = bv; iv8 = 1'b1;
    tick();
    iv8 = 1'b0;
    q8.push_back(16'(av) * 16'(bv));
    check("busy8_after_accept", 32'(bz8), 32'd1);
  endtask

  // Returns at the first cycle with out_valid high; checks latency and value.
  task automatic wait_result8(input int exp_lat);
    int k;
    logic [15:0] e;
    k = 0;
    while (!ov8 && k < 40) begin tick(); k++; end
    check("latency8", 32'(k), 32'(exp_lat));
    e = 16'hxxxx;
    if (q8.size() > 0) e = q8.pop_front();
    check("prod8", 32'(p8), 32'(e));
  endtask

  initial begin
    logic [7:0] pv;
    logic [3:0] pv2;
    logic [7:0] e4;
    int k;
    int n;
    bit done;
    bit stale;

    // Reset state
    #3;
    check("rst_in_ready8", 32'(ir8), 32'd1);
    check("rst_out_valid8", 32'(ov8), 32'd0);
    check("rst_busy8", 32'(bz8), 32'd0);
    check("rst_prod8", 32'(p8), 32'd0);
    check("rst_in_ready4", 32'(ir4), 32'd1);
    check("rst_in_ready2", 32'(ir2), 32'd1);
    tick();
    rst = 1'b0;
    tick();

    // 1: basic product, exact latency, single-cycle out_valid
    or8 = 1'b1;
    accept8(8'h12, 8'h34);
    wait_result8(16);
    tick();
    check("t1_valid_single", 32'(ov8), 32'd0);
    check("t1_in_ready_back", 32'(ir8), 32'd1);

    // 2: max operands, then zero operand
    accept8(8'hFF, 8'hFF);
    wait_result8(16);
    check("t2_ff_expect", 32'(p8), 32'h0000FE01);
    tick();
    accept8(8'h00, 8'hAB);
    wait_result8(16);
    tick();

    // 3: backpressure with ignored in_valid pulse
    or8 = 1'b0;
    accept8(8'h0B, 8'h0D);
    wait_result8(16);
    for (int c = 0; c < 5; c++) begin
      iv8 = (c == 2);
      a8 = 8'h77; b8 = 8'h11;
      tick();
      check("t3_hold_valid", 32'(ov8), 32'd1);
      check("t3_hold_prod", 32'(p8), 32'h0000008F);
      check("t3_hold_in_ready", 32'(ir8), 32'd0);
    end
    iv8 = 1'b0;
    or8 = 1'b1;
    tick();
    check("t3_release_valid", 32'(ov8), 32'd0);
    check("t3_release_in_ready", 32'(ir8), 32'd1);
    tick();
    check("t3_not_taken_busy", 32'(bz8), 32'd0);
    check("t3_not_taken_prod", 32'(p8), 32'h0000008F);

    // 4: asynchronous reset mid-RUN aborts the operation
    accept8(8'hC8, 8'h64);
    repeat (6) tick();
    #2;
    check("t4_busy_before_rst", 32'(bz8), 32'd1);
    rst = 1'b1;
    #1;
    check("t4_async_in_ready", 32'(ir8), 32'd1);
    check("t4_async_out_valid", 32'(ov8), 32'd0);
    check("t4_async_busy", 32'(bz8), 32'd0);
    tick();
    rst = 1'b0;
    q8.delete();
    stale = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (ov8) stale = 1'b1;
    end
    check("t4_no_stale_valid", 32'(stale), 32'd0);
    accept8(8'h03, 8'h05);
    wait_result8(16);
    check("t4_new_result", 32'(p8), 32'h0000000F);
    tick();
    check("t4_queue_empty", 32'(q8.size()), 32'd0);

    // 5: WIDTH=4 exhaustive with random gaps and random out_ready
    for (int p = 0; p < 256; p++) begin
      pv = 8'(p);
      n = $urandom_range(0, 2);
      for (int g = 0; g < n; g++) tick();
      n = 0;
      while (!ir4 && n < 50) begin tick(); n++; end
      a4 = pv[7:4]; b4 = pv[3:0]; iv4 = 1'b1;
      tick();
      iv4 = 1'b0;
      q4.push_back(8'(pv[7:4]) * 8'(pv[3:0]));
      done = 1'b0;
      k = 0;
      while (!done && k < 100) begin
        if (ov4) begin
          or4 = 1'($urandom_range(0, 1));
          if (or4) begin
            e4 = 8'hxx;
            if (q4.size() > 0) e4 = q4.pop_front();
            check("w4_prod", 32'(p4), 32'(e4));
            tick();
            check("w4_single_valid", 32'(ov4), 32'd0);
            done = 1'b1;
          end else begin
            tick();
          end
        end else begin
          tick();
        end
        k++;
      end
      or4 = 1'b0;
      check("w4_completed", 32'(done), 32'd1);
    end
    check("w4_queue_empty", 32'(q4.size()), 32'd0);

    // 6: WIDTH=2 all pairs, one-cycle RUN
    or2 = 1'b1;
    for (int p = 0; p < 16; p++) begin
      pv2 = 4'(p);
      a2 = pv2[3:2]; b2 = pv2[1:0]; iv2 = 1'b1;
      tick();
      iv2 = 1'b0;
      tick();
      check("w2_valid_lat1", 32'(ov2), 32'd1);
      check("w2_prod", 32'(p2), 32'(4'(pv2[3:2]) * 4'(pv2[1:0])));
      tick();
      check("w2_valid_drop", 32'(ov2), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
